// File: rtl/aluout_src_ctrl.sv
// Sequencer for the ALUOut source-select mux and ALUOut register load.
// Shift classes run a shifter load/shift handshake and an optional settle wait before capture.
module aluout_src_ctrl #(
  parameter int SEL_W      = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op_class,
  input  logic [2:0]       shift_kind,
  input  logic             flush,
  output logic [SEL_W-1:0] alu_out_sel,
  output logic             alu_out_load,
  output logic [2:0]       shift_ctrl,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SH_LOAD = 3'd1,
    SH_RUN  = 3'd2,
    SH_WAIT = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] CLS_SHIFT  = 3'b010;
  localparam logic [2:0] CTRL_HOLD  = 3'b000;
  localparam logic [2:0] CTRL_LOAD  = 3'b001;
  localparam logic [3:0] WAIT_INIT  = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       kind_q, kind_d;
  logic [SEL_W-1:0] sel_d;
  logic             err_d;
  logic             load_d, done_d, busy_d;
  logic [2:0]       ctrl_d;
  logic             legal_class, legal_shift;

  assign legal_class = (op_class inside {3'b000, 3'b001, 3'b011, 3'b100});
  assign legal_shift = (op_class == CLS_SHIFT) &&
                       (shift_kind inside {3'b010, 3'b011, 3'b100});

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    sel_d   = alu_out_sel;
    err_d   = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (legal_class) begin
              sel_d   = SEL_W'(op_class);
              state_d = WRITE;
            end else if (legal_shift) begin
              sel_d   = SEL_W'(CLS_SHIFT);
              kind_d  = shift_kind;
              state_d = SH_LOAD;
            end else begin
              err_d   = 1'b1;
            end
          end
        end
        SH_LOAD: state_d = SH_RUN;
        SH_RUN: begin
          if (SETTLE_CYC > 0) begin
            cnt_d   = WAIT_INIT;
            state_d = SH_WAIT;
          end else begin
            state_d = WRITE;
          end
        end
        SH_WAIT: begin
          if (cnt_q == 4'd0) state_d = WRITE;
          else               cnt_d   = cnt_q - 4'd1;
        end
        WRITE:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and then registered, so each one
  // lines up with the state it belongs to while coming straight from a flop.
  always_comb begin
    load_d = (state_d == WRITE);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
    ctrl_d = CTRL_HOLD;
    if (state_d == SH_LOAD)     ctrl_d = CTRL_LOAD;
    else if (state_d == SH_RUN) ctrl_d = kind_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      kind_q       <= 3'd0;
      alu_out_sel  <= '0;
      alu_out_load <= 1'b0;
      shift_ctrl   <= CTRL_HOLD;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      alu_out_sel  <= sel_d;
      alu_out_load <= load_d;
      shift_ctrl   <= ctrl_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_aluout_src_ctrl.sv
// Self-checking bench for aluout_src_ctrl: directed literal checks plus a randomized
// run compared every cycle against a transaction-level schedule model.
module tb_aluout_src_ctrl;

  localparam int SEL_W  = 3;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op_class = '0;
  logic [2:0]       shift_kind = '0;
  logic             flush = 1'b0;
  logic [SEL_W-1:0] alu_out_sel;
  logic             alu_out_load;
  logic [2:0]       shift_ctrl;
  logic             busy;
  logic             done;
  logic             err;

  int tests = 0;
  int fails = 0;

  aluout_src_ctrl #(.SEL_W(SEL_W), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_class(op_class),
    .shift_kind(shift_kind), .flush(flush), .alu_out_sel(alu_out_sel),
    .alu_out_load(alu_out_load), .shift_ctrl(shift_ctrl), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: an accepted request becomes a list of per-cycle output frames;
  // the controller is busy exactly while that list is non-empty.
  typedef struct packed {
    logic       load;
    logic       done;
    logic [2:0] ctrl;
  } frame_t;

  frame_t     sched[$];
  logic [2:0] m_sel = '0;
  logic       m_err = 1'b0;

  function automatic frame_t mk(input logic l, input logic d, input logic [2:0] c);
    frame_t f;
    f.load = l;
    f.done = d;
    f.ctrl = c;
    return f;
  endfunction

  task automatic model_step();
    bit was_busy;
    was_busy = (sched.size() != 0);
    if (was_busy) void'(sched.pop_front());
    m_err = 1'b0;
    if (flush) begin
      if (was_busy) sched.delete();
    end else if (!was_busy && start) begin
      if (op_class inside {3'd0, 3'd1, 3'd3, 3'd4}) begin
        m_sel = op_class;
        sched.push_back(mk(1'b1, 1'b0, 3'd0));
        sched.push_back(mk(1'b0, 1'b1, 3'd0));
      end else if (op_class == 3'd2 && shift_kind inside {3'd2, 3'd3, 3'd4}) begin
        m_sel = 3'd2;
        sched.push_back(mk(1'b0, 1'b0, 3'd1));
        sched.push_back(mk(1'b0, 1'b0, shift_kind));
        for (int i = 0; i < SETTLE; i++) sched.push_back(mk(1'b0, 1'b0, 3'd0));
        sched.push_back(mk(1'b1, 1'b0, 3'd0));
        sched.push_back(mk(1'b0, 1'b1, 3'd0));
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // Compare process: advance the model on each rising edge, check just after it.
  always @(posedge clk) begin
    frame_t f;
    if (!reset_n) begin
      sched.delete();
      m_sel = '0;
      m_err = 1'b0;
    end else begin
      model_step();
    end
    #1;
    f = (sched.size() != 0) ? sched[0] : '0;
    check("sel",  32'(alu_out_sel),  32'(m_sel));
    check("load", 32'(alu_out_load), 32'(f.load));
    check("done", 32'(done),         32'(f.done));
    check("ctrl", 32'(shift_ctrl),   32'(f.ctrl));
    check("busy", 32'(busy),         32'(sched.size() != 0));
    check("err",  32'(err),          32'(m_err));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; op_class = '0; shift_kind = '0; flush = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_sel", 32'(alu_out_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // ALU class: load+sel in cycle 1, done in cycle 2.
    start = 1'b1; op_class = 3'b001;
    tick(); idle_inputs();
    check("alu_c1_load", 32'(alu_out_load), 32'd1);
    check("alu_c1_sel",  32'(alu_out_sel),  32'd1);
    check("alu_c1_busy", 32'(busy),         32'd1);
    tick();
    check("alu_c2_done", 32'(done), 32'd1);
    check("alu_c2_busy", 32'(busy), 32'd1);
    tick();
    check("alu_c3_busy", 32'(busy), 32'd0);

    // sra shift with one settle cycle.
    start = 1'b1; op_class = 3'b010; shift_kind = 3'b100;
    tick(); idle_inputs();
    check("sh_c1_ctrl", 32'(shift_ctrl), 32'd1);
    tick();
    check("sh_c2_ctrl", 32'(shift_ctrl), 32'd4);
    tick();
    check("sh_c3_ctrl", 32'(shift_ctrl), 32'd0);
    check("sh_c3_load", 32'(alu_out_load), 32'd0);
    tick();
    check("sh_c4_load", 32'(alu_out_load), 32'd1);
    check("sh_c4_sel",  32'(alu_out_sel),  32'd2);
    tick();
    check("sh_c5_done", 32'(done), 32'd1);
    tick();

    // Illegal class, then illegal shift kind.
    start = 1'b1; op_class = 3'b110;
    tick(); idle_inputs();
    check("ill_cls_err",  32'(err),         32'd1);
    check("ill_cls_busy", 32'(busy),        32'd0);
    check("ill_cls_sel",  32'(alu_out_sel), 32'd2);
    tick();
    check("ill_cls_err_end", 32'(err), 32'd0);
    start = 1'b1; op_class = 3'b010; shift_kind = 3'b111;
    tick(); idle_inputs();
    check("ill_kind_err",  32'(err),         32'd1);
    check("ill_kind_busy", 32'(busy),        32'd0);
    check("ill_kind_sel",  32'(alu_out_sel), 32'd2);
    tick();

    // Start held while busy must be ignored.
    start = 1'b1; op_class = 3'b011;
    tick(); op_class = 3'b001;
    check("hold_c1_load", 32'(alu_out_load), 32'd1);
    check("hold_c1_sel",  32'(alu_out_sel),  32'd3);
    tick();
    check("hold_c2_done", 32'(done), 32'd1);
    check("hold_c2_sel",  32'(alu_out_sel), 32'd3);
    idle_inputs();
    tick();
    check("hold_c3_busy", 32'(busy), 32'd0);
    check("hold_c3_load", 32'(alu_out_load), 32'd0);
    check("hold_c3_sel",  32'(alu_out_sel), 32'd3);

    // Flush during SH_RUN.
    start = 1'b1; op_class = 3'b010; shift_kind = 3'b010;
    tick(); idle_inputs();
    tick();
    check("fl_c2_ctrl", 32'(shift_ctrl), 32'd2);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("fl_c3_busy", 32'(busy), 32'd0);
    check("fl_c3_ctrl", 32'(shift_ctrl), 32'd0);
    check("fl_c3_load", 32'(alu_out_load), 32'd0);
    tick();
    check("fl_c4_load", 32'(alu_out_load), 32'd0);
    check("fl_c4_done", 32'(done), 32'd0);

    // Flush together with start in IDLE: nothing latched.
    start = 1'b1; op_class = 3'b100; flush = 1'b1;
    tick(); idle_inputs();
    check("fl_idle_busy", 32'(busy), 32'd0);
    check("fl_idle_sel",  32'(alu_out_sel), 32'd2);

    // Async reset in SH_RUN.
    start = 1'b1; op_class = 3'b010; shift_kind = 3'b011;
    tick(); idle_inputs();
    tick();
    check("rs_c2_ctrl", 32'(shift_ctrl), 32'd3);
    reset_n = 1'b0;
    #1;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_ctrl", 32'(shift_ctrl), 32'd0);
    check("rs_sel",  32'(alu_out_sel), 32'd0);
    check("rs_load", 32'(alu_out_load), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rs_no_done", 32'(done), 32'd0);
      check("rs_no_load", 32'(alu_out_load), 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 99) < 45);
      op_class   = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      shift_kind = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 99) < 4);
      reset_n    = ($urandom_range(0, 999) >= 4);
      tick();
    end
    idle_inputs();
    reset_n = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
